// File: rtl/blink_period_meter.sv
// blink_period_meter: measures the half-period of an external toggling
// signal in whole milliseconds. It reports the result as the 16-bit speed
// word that a blink generator consumes ("toggle every speed ms ticks").
// It has its own ms prescaler, input synchronizer, edge detector and a
// lock/timeout FSM.
module blink_period_meter #(
  parameter int CLK_PER_MS  = 100000,
  parameter int TIMEOUT_MS  = 65535,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        blink_in,
  output logic [15:0] speed,
  output logic        speed_valid,
  output logic        locked,
  output logic        timeout
);

  localparam int            PW         = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_MS - 1);
  localparam logic [16:0]   TIMEOUT_M  = 17'(TIMEOUT_MS);

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_t;

  // Input conditioning
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   edge_seen;

  // Millisecond timebase
  logic [PW-1:0]          presc_q;
  logic [PW-1:0]          presc_d;
  logic                   tic;

  // Half-period measurement
  logic [15:0]            ms_q;
  logic [15:0]            ms_d;
  logic [16:0]            m;
  logic                   accept;
  logic                   expire;

  // FSM and registered outputs
  state_t                 state_q;
  logic [15:0]            speed_q;
  logic                   speed_valid_q;
  logic                   locked_q;
  logic                   timeout_q;

  // Bring blink_in into the clk domain and keep the previous settled level
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], blink_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Either polarity of transition marks one half-period boundary.
  assign edge_seen = sync_q[SYNC_STAGES-1] ^ prev_q;

  assign tic = (presc_q == PRESC_LAST);

  // A tic landing in the same cycle as the edge still counts toward the
  // measurement, so the elapsed whole-ms figure includes it.
  assign m = {1'b0, ms_q} + {16'd0, tic};

  // In IDLE any edge arms the meter. In ARMED an edge is accepted only when
  // at least one whole ms has elapsed. Anything shorter is a glitch.
  assign accept = edge_seen && ((state_q == IDLE) || (m != 17'd0));

  // The timeout fires only when no edge arrives in the same cycle. A
  // coincident edge wins and reports speed = TIMEOUT_MS instead.
  assign expire = (state_q == ARMED) && !edge_seen && (m >= TIMEOUT_M);

  // Prescaler next state: wrap on tic, and realign to an accepted edge
  always_comb begin
    presc_d = presc_q + PW'(1);
    if (accept || tic) begin
      presc_d = '0;
    end
  end

  // Elapsed-ms next state: only advances while ARMED and no edge is accepted
  always_comb begin
    ms_d = ms_q;
    if (state_q == IDLE || accept || expire) begin
      ms_d = '0;
    end else begin
      ms_d = m[15:0];
    end
  end

  // Timebase and elapsed-ms registers
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      ms_q    <= '0;
    end else begin
      presc_q <= presc_d;
      ms_q    <= ms_d;
    end
  end

  // Lock/timeout FSM with registered speed, lock and pulse outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      speed_q       <= '0;
      speed_valid_q <= 1'b0;
      locked_q      <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      speed_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (edge_seen) begin
            state_q <= ARMED;
          end
        end
        ARMED: begin
          if (accept) begin
            speed_q       <= m[15:0];
            speed_valid_q <= 1'b1;
            locked_q      <= (m[15:0] == speed_q) && (speed_q != 16'd0);
          end else if (expire) begin
            timeout_q <= 1'b1;
            speed_q   <= '0;
            locked_q  <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign speed       = speed_q;
  assign speed_valid = speed_valid_q;
  assign locked      = locked_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_blink_period_meter.sv
// Self-checking bench for blink_period_meter. It runs the directed
// scenarios with literal expectations, then a randomized toggle/reset
// phase. Every cycle is checked against a cycle-count reference model.
module tb_blink_period_meter;

  localparam int CPM = 10;
  localparam int TOM = 50;
  localparam int SS  = 2;

  logic        clk      = 1'b0;
  logic        rst      = 1'b1;
  logic        blink_in = 1'b0;
  logic [15:0] speed;
  logic        speed_valid;
  logic        locked;
  logic        timeout;

  int n_cmp = 0;
  int n_bad = 0;

  blink_period_meter #(
    .CLK_PER_MS (CPM),
    .TIMEOUT_MS (TOM),
    .SYNC_STAGES(SS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .blink_in   (blink_in),
    .speed      (speed),
    .speed_valid(speed_valid),
    .locked     (locked),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model. It counts the posedges since the last accepted edge as
  // seen after the synchronizer delay. The elapsed whole ms is k / CPM.
  bit dly [SS+1];
  bit m_ready  = 1'b0;
  bit m_armed  = 1'b0;
  int m_k      = 0;
  int m_speed  = 0;
  bit m_locked = 1'b0;
  bit m_valid  = 1'b0;
  bit m_to     = 1'b0;

  always @(posedge clk) begin
    bit e;
    int ms;
    if (rst) begin
      for (int i = 0; i <= SS; i++) dly[i] = 1'b0;
      m_armed  = 1'b0;
      m_k      = 0;
      m_speed  = 0;
      m_locked = 1'b0;
      m_valid  = 1'b0;
      m_to     = 1'b0;
      m_ready  = 1'b1;
    end else begin
      e       = dly[SS-1] ^ dly[SS];
      m_valid = 1'b0;
      m_to    = 1'b0;
      if (!m_armed) begin
        if (e) begin
          m_armed = 1'b1;
          m_k     = 0;
        end
      end else begin
        ms = (m_k + 1) / CPM;
        if (e && ms >= 1) begin
          m_locked = (ms == m_speed) && (m_speed != 0);
          m_speed  = ms;
          m_valid  = 1'b1;
          m_k      = 0;
        end else if (!e && ms >= TOM) begin
          m_to     = 1'b1;
          m_speed  = 0;
          m_locked = 1'b0;
          m_armed  = 1'b0;
          m_k      = 0;
        end else begin
          m_k = m_k + 1;
        end
      end
      for (int i = SS; i > 0; i--) dly[i] = dly[i-1];
      dly[0] = blink_in;
    end
  end

  // Compare the DUT with the model on every cycle once the model is in step
  always @(negedge clk) begin
    if (m_ready) begin
      chk("model.speed",       int'(speed),       m_speed);
      chk("model.speed_valid", int'(speed_valid), int'(m_valid));
      chk("model.locked",      int'(locked),      int'(m_locked));
      chk("model.timeout",     int'(timeout),     int'(m_to));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_out(input string tag, input int sp, input int vl,
                            input int lk, input int to);
    chk({tag, ".speed"},       int'(speed),       sp);
    chk({tag, ".speed_valid"}, int'(speed_valid), vl);
    chk({tag, ".locked"},      int'(locked),      lk);
    chk({tag, ".timeout"},     int'(timeout),     to);
  endtask

  // Toggle 'gap' cycles after the previous toggle. The call is entered 3
  // cycles after that toggle. The outputs are checked 3 cycles after this
  // toggle.
  task automatic tc(input int gap, input string tag, input int sp,
                    input int vl, input int lk);
    step(gap - 3);
    blink_in = ~blink_in;
    step(3);
    expect_out(tag, sp, vl, lk, 0);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    blink_in = 1'b0;
    step(4);
    rst = 1'b0;
    step(2);
  endtask

  initial begin : main
    int gap;
    int last_gap;
    int r;
    last_gap = 30;

    step(1);

    // 1: reset held while blink_in toggles every cycle
    for (int i = 0; i < 5; i++) begin
      blink_in = ~blink_in;
      step(1);
      expect_out("s1_rst", 0, 0, 0, 0);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      expect_out("s1_post", 0, 0, 0, 0);
    end
    do_reset();

    // 2: steady 30-cycle half-period
    tc(5,  "s2_e1", 0, 0, 0);
    tc(30, "s2_e2", 3, 1, 0);
    tc(30, "s2_e3", 3, 1, 1);

    // 3: rate change to 50 cycles
    tc(50, "s3_e1", 5, 1, 0);
    tc(50, "s3_e2", 5, 1, 1);

    // 4: glitch 4 cycles after an accepted edge, then an edge at 30
    tc(4,  "s4_glitch", 5, 0, 1);
    tc(26, "s4_e",      3, 1, 0);

    // 5: timeout 500 cycles after the last accepted edge
    step(499);
    expect_out("s5_pre",  3, 0, 0, 0);
    step(1);
    expect_out("s5_to",   0, 0, 0, 1);
    step(1);
    expect_out("s5_post", 0, 0, 0, 0);
    tc(3,  "s5_rearm", 0, 0, 0);
    tc(20, "s5_e",     2, 1, 0);

    // 6: reset 15 cycles after an accepted edge
    step(12);
    rst      = 1'b1;
    blink_in = 1'b0;
    step(1);
    expect_out("s6_rst", 0, 0, 0, 0);
    step(1);
    rst = 1'b0;
    tc(5,  "s6_e1", 0, 0, 0);
    tc(30, "s6_e2", 3, 1, 0);

    // Randomized toggle intervals with occasional resets
    do_reset();
    for (int i = 0; i < 90; i++) begin
      r = $urandom_range(0, 99);
      if (r < 8) begin
        gap = $urandom_range(1, 9);
      end else if (r < 12) begin
        gap = 500;
      end else if (r < 16) begin
        gap = $urandom_range(480, 560);
      end else if (r < 19) begin
        rst = 1'b1;
        step($urandom_range(1, 4));
        rst = 1'b0;
        gap = $urandom_range(1, 40);
      end else if (r < 45) begin
        gap = last_gap;
      end else begin
        gap = $urandom_range(10, 120);
      end
      last_gap = gap;
      step(gap);
      blink_in = ~blink_in;
    end
    step(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/blink_period_meter.md
Name: blink_period_meter

Overview:
- Receive side of the LED blink scheme: observes an externally driven toggling signal and measures its half-period in whole milliseconds.
- Reports the result as a 16-bit speed word in the same units a blink generator consumes: toggle every `speed` ms ticks.
- Used for loopback self-test and for recovering the blink rate from a pin.
- Contains its own millisecond prescaler, input synchronizer, edge detector and lock/timeout FSM.

Parameters:
- CLK_PER_MS, 100000, clk cycles per 1 ms tick (>=2).
- TIMEOUT_MS, 65535, ms without an edge before measurement is abandoned (1..65535).
- SYNC_STAGES, 2, flops in the blink_in synchronizer (>=2).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, synchronous, active-high.
- blink_in  input  1  asynchronous toggling signal under measurement.
- speed  output  16  last accepted half-period in ms; 0 = no valid measurement.
- speed_valid  output  1  one-cycle pulse when speed is updated.
- locked  output  1  high after two consecutive equal measurements.
- timeout  output  1  one-cycle pulse when TIMEOUT_MS elapses with no edge.

Behaviour:
- Clock and reset:
  - One clock domain, clk.
  - rst is synchronous, active-high, and sampled only on posedge clk.
  - Reset clears the sync chain, prev-level, prescaler, ms_count, FSM (IDLE), speed=0, speed_valid=0, locked=0, timeout=0.
  - Reset asserted mid-measurement discards the measurement in progress; no pulse is emitted.
- Synchronizer: SYNC_STAGES flops, all reset to 0.
- Edge detect:
  - `edge` = last sync stage XOR registered previous level.
  - Both edges count, because each edge is one half-period.
- Prescaler:
  - Counts 0..CLK_PER_MS-1; `tic` is high when count == CLK_PER_MS-1, then the count wraps to 0.
  - An accepted edge clears the prescaler to 0, so ms counting is aligned to the edge.
- ms_count:
  - 16-bit counter, increments on tic while ARMED.
  - Never exceeds TIMEOUT_MS.
- FSM state IDLE:
  - Outputs are held.
  - An edge moves the FSM to ARMED and clears ms_count and the prescaler. No speed_valid on this edge.
- FSM state ARMED, edge arrives. Let m = ms_count + tic (same-cycle tic is counted).
  - If m >= 1:
    - speed <= m and speed_valid pulses.
    - locked <= (m == previous speed && previous speed != 0).
    - ms_count and the prescaler are cleared.
  - If m == 0 (half-period < 1 ms): the edge is treated as a glitch. It is ignored, with no output change and no counter clear.
- FSM state ARMED, no edge:
  - When m reaches TIMEOUT_MS: timeout pulses, speed <= 0, locked <= 0, FSM returns to IDLE.
  - An edge in the same cycle takes priority and yields speed = TIMEOUT_MS, with no timeout.
- Latency: with SYNC_STAGES=2, speed and speed_valid update on the 3rd posedge clk after blink_in changes (SYNC_STAGES+1 in general).
- Output registers:
  - speed, locked and timeout are registered.
  - speed_valid and timeout are never high in the same cycle.
  - speed holds its value between pulses.

Test Plan:
- Use CLK_PER_MS=10, TIMEOUT_MS=50 for all scenarios.
1. Reset: hold rst 5 cycles while blink_in toggles every cycle -> speed=0, speed_valid=0, locked=0, timeout=0 throughout, and for 3 cycles after release.
2. Steady rate: toggle blink_in every 30 cycles -> 1st edge produces no pulse. 2nd edge: speed=3 and speed_valid 1 cycle, 3 cycles after the edge. 3rd edge: speed=3, locked=1.
3. Rate change: switch to toggling every 50 cycles while locked -> next measurement speed=5, locked=0. Following measurement: speed=5, locked=1.
4. Glitch: an extra blink_in edge 4 cycles after an accepted edge -> no speed_valid, counters not cleared. Next edge 30 cycles after the accepted edge gives speed=3.
5. Timeout: stop toggling after a speed=3 measurement -> 500 cycles after the last edge, timeout pulses once, speed=0, locked=0. Next edge rearms with no speed_valid; the following edge at 20 cycles gives speed=2.
6. Reset mid-measurement: assert rst 15 cycles after an accepted edge -> all outputs 0 the cycle after rst. The first post-reset edge produces no pulse.
